// File: rtl/umi_arb_pkg.sv
// umi_arb_pkg: shared constants and helpers for the UMI arbiter
package umi_arb_pkg;
    localparam int UMI_WRITE_BIT = 0;
    localparam int N_DEF = 4;
    localparam int PTR_W_DEF = $clog2(N_DEF);

    function automatic int ptr_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/umi_arbiter_if.sv
// umi_arbiter_if: requester-side and consumer-side signals of the arbiter
interface umi_arbiter_if
    import umi_arb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int UW = 256
);
    logic [N-1:0]          in_valid;
    logic [N*UW-1:0]       in_packet;
    logic [N-1:0]          in_ready;
    logic                  out_valid;
    logic [UW-1:0]         out_packet;
    logic                  out_ready;
    logic [ptr_w(N)-1:0]   grant_id;

    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_packet, grant_id
    );
    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_packet, grant_id
    );
endinterface

// File: rtl/umi_rr_arbiter.sv
// umi_rr_arbiter: combinational round-robin pick starting at ptr
module umi_rr_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]          req,
    input  logic [ptr_w(N)-1:0]   ptr,
    input  logic                  en,
    output logic [N-1:0]          gnt,
    output logic [ptr_w(N)-1:0]   gnt_idx
);
    localparam int PW = ptr_w(N);

    function automatic int wrap(input int j);
        return (j >= N) ? j - N : j;
    endfunction

    logic found;

    // first requester at or after ptr, wrapping past N-1
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[wrap(int'(ptr) + k)]) begin
                found                       = 1'b1;
                gnt[wrap(int'(ptr) + k)]    = 1'b1;
                gnt_idx                     = PW'(wrap(int'(ptr) + k));
            end
        end
    end
endmodule

// File: rtl/umi_arbiter.sv
// umi_arbiter: two-class round-robin arbiter with starvation guard and registered output
module umi_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int AW           = 64,
    parameter int UW           = 256,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        nreset,
    umi_arbiter_if.slave bus
);
    localparam int PW = ptr_w(N);
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam bit CFG_OK = (AW == 64) && (UW == 256);

    logic [N-1:0]  hi_req, lo_req, hi_gnt, lo_gnt, grant;
    logic [PW-1:0] hi_idx, lo_idx, gnt_idx;
    logic [PW-1:0] hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d, grant_id_q, grant_id_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          out_valid_q, out_valid_d;
    logic [UW-1:0] out_packet_q, out_packet_d;
    logic          force_lo, hi_sel, load, xfer;

    // split requests into classes by the write bit
    always_comb begin
        hi_req = '0;
        lo_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = bus.in_valid[i] &  bus.in_packet[i*UW + UMI_WRITE_BIT];
            lo_req[i] = bus.in_valid[i] & ~bus.in_packet[i*UW + UMI_WRITE_BIT];
        end
    end

    assign force_lo = (STARVE_LIMIT != 0) && (starve_q == SW'(STARVE_LIMIT)) && |lo_req;
    assign hi_sel   = |hi_req && !force_lo;

    umi_rr_arbiter #(.N(N)) u_hi (.req(hi_req), .ptr(hi_ptr_q), .en(hi_sel),  .gnt(hi_gnt), .gnt_idx(hi_idx));
    umi_rr_arbiter #(.N(N)) u_lo (.req(lo_req), .ptr(lo_ptr_q), .en(!hi_sel), .gnt(lo_gnt), .gnt_idx(lo_idx));

    assign grant        = hi_gnt | lo_gnt;
    assign gnt_idx      = hi_sel ? hi_idx : lo_idx;
    assign load         = CFG_OK && (!out_valid_q || bus.out_ready);
    assign xfer         = load && |grant;
    assign bus.in_ready = (load && nreset) ? grant : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_packet = out_packet_q;
    assign bus.grant_id   = grant_id_q;

    // next state: load granted packet, advance the winning class pointer, track starvation
    always_comb begin
        out_valid_d  = load ? xfer : out_valid_q;
        out_packet_d = xfer ? bus.in_packet[gnt_idx*UW +: UW] : out_packet_q;
        grant_id_d   = xfer ? gnt_idx : grant_id_q;
        hi_ptr_d     = (xfer && hi_sel)  ? PW'(next_idx(int'(hi_idx), N)) : hi_ptr_q;
        lo_ptr_d     = (xfer && !hi_sel) ? PW'(next_idx(int'(lo_idx), N)) : lo_ptr_q;
        starve_d     = !xfer ? starve_q :
                       (hi_sel && |lo_req) ? ((starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1) :
                       '0;
    end

    // state registers, cleared asynchronously
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            grant_id_q   <= '0;
            hi_ptr_q     <= '0;
            lo_ptr_q     <= '0;
            starve_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            grant_id_q   <= grant_id_d;
            hi_ptr_q     <= hi_ptr_d;
            lo_ptr_q     <= lo_ptr_d;
            starve_q     <= starve_d;
        end
    end
endmodule

// File: tb/tb_umi_arbiter.sv
// tb_umi_arbiter: table vectors, directed corner sequences and random traffic against a reference model
module tb_umi_arbiter;
    localparam int N   = 4;
    localparam int UW  = 256;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic nreset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    umi_arbiter_if #(.N(N), .UW(UW)) bus ();

    umi_arbiter #(.N(N), .AW(64), .UW(UW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus)
    );

    // reference model state: what the output register and arbiter should hold
    int            m_ov, m_gid, m_hp, m_lp, m_st;
    logic [UW-1:0] m_pkt;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] c;
        logic         o;
        logic [N-1:0] rdy;
        logic         ov;
        int           gid;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_ov = 0; m_gid = 0; m_hp = 0; m_lp = 0; m_st = 0; m_pkt = '0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] c, input logic o);
        logic [UW-1:0] pk;
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < UW / 32; w++) pk[w*32 +: 32] = $urandom;
            pk[0] = c[i];
            bus.in_packet[i*UW +: UW] = pk;
        end
        bus.in_valid  = v;
        bus.out_ready = o;
    endtask

    // compare DUT against the model for this cycle, then advance the model across the edge
    task automatic cycle();
        logic [N-1:0] hi, lo;
        int load, fl, hs, idx, er;
        #1;
        for (int i = 0; i < N; i++) begin
            hi[i] = bus.in_valid[i] &  bus.in_packet[i*UW];
            lo[i] = bus.in_valid[i] & ~bus.in_packet[i*UW];
        end
        load = (m_ov == 0 || bus.out_ready) ? 1 : 0;
        fl   = (LIM != 0 && m_st == LIM && lo != 0) ? 1 : 0;
        hs   = (hi != 0 && fl == 0) ? 1 : 0;
        idx  = hs ? pick(hi, m_hp) : pick(lo, m_lp);
        er   = (load != 0 && idx >= 0) ? (1 << idx) : 0;
        chk("in_ready", UW'(bus.in_ready), UW'(er));
        chk("out_valid", UW'(bus.out_valid), UW'(m_ov));
        chk("grant_id", UW'(bus.grant_id), UW'(m_gid));
        chk("out_packet", bus.out_packet, m_pkt);
        @(posedge clk);
        if (load != 0) begin
            if (idx >= 0) begin
                m_ov  = 1;
                m_pkt = bus.in_packet[idx*UW +: UW];
                m_gid = idx;
                if (hs != 0) m_hp = (idx + 1) % N;
                else         m_lp = (idx + 1) % N;
                m_st = (hs != 0 && lo != 0) ? ((m_st < LIM) ? m_st + 1 : LIM) : 0;
            end else begin
                m_ov = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        tv[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 0};
        tv[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 1};
        tv[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2};
        tv[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 3};
        tv[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 0};
        tv[5]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2};
        tv[6]  = '{4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2};
        tv[7]  = '{4'b0101, 4'b0100, 1'b0, 4'b0000, 1'b1, 2};
        tv[8]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 0};
        tv[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};
        tv[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        tv[11] = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 3};

        nreset = 1'b0;
        drive(4'b1111, 4'b0000, 1'b1);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", UW'(bus.out_valid), '0);
        chk("rst_in_ready", UW'(bus.in_ready), '0);
        chk("rst_grant_id", UW'(bus.grant_id), '0);
        nreset = 1'b1;

        for (int r = 0; r < 12; r++) begin
            drive(tv[r].v, tv[r].c, tv[r].o);
            #1;
            chk($sformatf("tbl%0d_ready", r), UW'(bus.in_ready), UW'(tv[r].rdy));
            cycle();
            chk($sformatf("tbl%0d_valid", r), UW'(bus.out_valid), UW'(tv[r].ov));
            chk($sformatf("tbl%0d_gid", r), UW'(bus.grant_id), UW'(tv[r].gid));
        end

        drive(4'b1111, 4'b0000, 1'b1);
        cycle();
        for (int c = 0; c < 5; c++) begin
            drive(4'b1111, 4'($urandom), 1'b0);
            cycle();
        end
        for (int c = 0; c < 6; c++) begin
            drive(4'b1111, 4'($urandom), 1'b1);
            cycle();
        end

        for (int c = 0; c < 400; c++) begin
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
            cycle();
        end

        drive(4'b0010, 4'b0010, 1'b1);
        cycle();
        drive(4'b0010, 4'b0000, 1'b1);
        cycle();
        #2 nreset = 1'b0;
        #1;
        chk("arst_out_valid", UW'(bus.out_valid), '0);
        chk("arst_grant_id", UW'(bus.grant_id), '0);
        chk("arst_out_packet", bus.out_packet, '0);
        m_reset();
        @(negedge clk);
        nreset = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1);
        cycle();
        chk("arst_hi_ptr", UW'(bus.grant_id), '0);
        drive(4'b1111, 4'b0000, 1'b1);
        cycle();
        chk("arst_lo_ptr", UW'(bus.grant_id), '0);

        for (int c = 0; c < 18; c++) begin
            drive(4'b1010, 4'b0010, 1'b1);
            cycle();
            chk($sformatf("starve%0d", c), UW'(bus.grant_id), UW'((c % 9 == 8) ? 3 : 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
